// File: rtl/yutorina_if_stage.sv
// yutorina_if_stage: instruction-fetch stage of the Yutorina pipeline.
// Owns the PC, fetches words over an active-low req/rdy bus and hands the
// fetched instruction to ID through if_en_/if_pc/if_insn.
//
// Optional feature macro: YUTORINA_IF_BUS_TIMEOUT_EN
//   When defined, a bus watchdog stops fetching after TIMEOUT cycles without
//   rdy, pulses if_bus_err and parks the stage in HALT until a flush.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | first cycle after reset, no request outstanding yet
// ST_REQ     | request at bus_addr outstanding, its data will be used
// ST_DISCARD | request outstanding but redirected, its data will be dropped
// ST_PEND    | word arrived during a stall, parked in the pending buffer
// ST_HALT    | bus watchdog fired, waiting for a flush (optional feature)

module yutorina_if_stage #(
  parameter int                ADDR_W       = 30,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              bus_req_,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rdy_,
  input  logic [DATA_W-1:0] bus_rd_data,
  output logic              if_en_,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_bus_err
);

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DISCARD,
    ST_PEND
`ifdef YUTORINA_IF_BUS_TIMEOUT_EN
    ,
    ST_HALT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              if_en_q, if_en_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_insn_q, if_insn_d;
  // The pending buffer only holds meaningful contents while in ST_PEND,
  // so the state itself serves as its valid flag.
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [DATA_W-1:0] pend_insn_q, pend_insn_d;

  logic              rdy;
  logic              redir;
  logic [ADDR_W-1:0] redir_pc;

`ifdef YUTORINA_IF_BUS_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  // Count of waiting cycles already elapsed; the TIMEOUT-th waiting cycle fires.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            if_bus_err_q, if_bus_err_d;
`endif

  assign rdy      = (bus_rdy_ == ENABLE_);
  // flush wins over a branch; a branch is ignored while the pipe is stalled.
  assign redir    = flush | (br_taken & ~stall);
  assign redir_pc = flush ? new_pc : br_addr;

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    if_en_d     = if_en_q;
    if_pc_d     = if_pc_q;
    if_insn_d   = if_insn_q;
    pend_pc_d   = pend_pc_q;
    pend_insn_d = pend_insn_q;
`ifdef YUTORINA_IF_BUS_TIMEOUT_EN
    wd_cnt_d     = '0;
    if_bus_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          pc_d = new_pc;
        end
        bus_req_d  = ENABLE_;
        bus_addr_d = flush ? new_pc : pc_q;
        state_d    = ST_REQ;
      end

      ST_REQ: begin
        if (redir) begin
          pc_d    = redir_pc;
          if_en_d = DISABLE_;
          if (rdy) begin
            // Current word is stale; reissue straight away at the target.
            bus_addr_d = redir_pc;
          end else begin
            // Request cannot be withdrawn; let it finish and drop the data.
            state_d = ST_DISCARD;
          end
        end else if (rdy) begin
          if (stall) begin
            pend_pc_d   = pc_q;
            pend_insn_d = bus_rd_data;
            bus_req_d   = DISABLE_;
            state_d     = ST_PEND;
          end else begin
            if_en_d    = ENABLE_;
            if_pc_d    = pc_q;
            if_insn_d  = bus_rd_data;
            pc_d       = pc_q + 1'b1;
            bus_addr_d = pc_q + 1'b1;
          end
        end else if (!stall) begin
          if_en_d = DISABLE_;
        end
      end

      ST_DISCARD: begin
        if (redir) begin
          pc_d = redir_pc;
        end
        if (rdy) begin
          bus_addr_d = redir ? redir_pc : pc_q;
          state_d    = ST_REQ;
        end
      end

      ST_PEND: begin
        if (redir) begin
          // A redirect makes the parked word stale.
          if_en_d    = DISABLE_;
          pc_d       = redir_pc;
          bus_req_d  = ENABLE_;
          bus_addr_d = redir_pc;
          state_d    = ST_REQ;
        end else if (!stall) begin
          if_en_d    = ENABLE_;
          if_pc_d    = pend_pc_q;
          if_insn_d  = pend_insn_q;
          pc_d       = pend_pc_q + 1'b1;
          bus_req_d  = ENABLE_;
          bus_addr_d = pend_pc_q + 1'b1;
          state_d    = ST_REQ;
        end
      end

`ifdef YUTORINA_IF_BUS_TIMEOUT_EN
      ST_HALT: begin
        if (flush) begin
          pc_d       = new_pc;
          bus_req_d  = ENABLE_;
          bus_addr_d = new_pc;
          state_d    = ST_REQ;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef YUTORINA_IF_BUS_TIMEOUT_EN
    // Watchdog: count consecutive unanswered cycles; cleared by rdy or by any
    // state change. A flush on the firing cycle is honoured first and the
    // count is kept so the watchdog can still fire if the wait continues.
    if (((state_q == ST_REQ) || (state_q == ST_DISCARD)) && !rdy) begin
      if (wd_cnt_q == WD_LIMIT) begin
        if (!flush) begin
          bus_req_d    = DISABLE_;
          if_en_d      = DISABLE_;
          if_bus_err_d = 1'b1;
          state_d      = ST_HALT;
        end else if (state_d == state_q) begin
          wd_cnt_d = wd_cnt_q;
        end
      end else if (state_d == state_q) begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
`endif
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_VECTOR;
      bus_req_q   <= DISABLE_;
      bus_addr_q  <= '0;
      if_en_q     <= DISABLE_;
      if_pc_q     <= '0;
      if_insn_q   <= '0;
      pend_pc_q   <= '0;
      pend_insn_q <= '0;
`ifdef YUTORINA_IF_BUS_TIMEOUT_EN
      wd_cnt_q     <= '0;
      if_bus_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      if_en_q     <= if_en_d;
      if_pc_q     <= if_pc_d;
      if_insn_q   <= if_insn_d;
      pend_pc_q   <= pend_pc_d;
      pend_insn_q <= pend_insn_d;
`ifdef YUTORINA_IF_BUS_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
      if_bus_err_q <= if_bus_err_d;
`endif
    end
  end

  assign bus_req_ = bus_req_q;
  assign bus_addr = bus_addr_q;
  assign if_en_   = if_en_q;
  assign if_pc    = if_pc_q;
  assign if_insn  = if_insn_q;
`ifdef YUTORINA_IF_BUS_TIMEOUT_EN
  assign if_bus_err = if_bus_err_q;
`else
  assign if_bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_yutorina_if_stage.sv
// Testbench for yutorina_if_stage: random bus wait states, stalls, branches
// and flushes, checked against an instruction-stream reference model.
module tb_yutorina_if_stage;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          stall, flush, br_taken;
  logic [AW-1:0] new_pc, br_addr;
  logic          bus_req_;
  logic [AW-1:0] bus_addr;
  logic          bus_rdy_;
  logic [DW-1:0] bus_rd_data;
  logic          if_en_;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_insn;
  logic          if_bus_err;

  yutorina_if_stage #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .RESET_VECTOR(30'h100),
    .TIMEOUT     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .bus_req_   (bus_req_),
    .bus_addr   (bus_addr),
    .bus_rdy_   (bus_rdy_),
    .bus_rd_data(bus_rd_data),
    .if_en_     (if_en_),
    .if_pc      (if_pc),
    .if_insn    (if_insn),
    .if_bus_err (if_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int            at;
    logic [AW-1:0] tgt;
  } redir_t;
  redir_t redir_q[$];

  // Memory contents seen by the fetch stage.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]} ^ {a[29:14], 16'h0} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bus responder: per-request wait states, data valid with rdy.
  int   fixed_waits = 0;
  bit   rand_waits  = 0;
  bit   bus_hang    = 0;
  int   wait_left   = 0;
  always @(posedge clk) begin
    #2;
    if (rst && !bus_req_ && !bus_hang) begin
      if (wait_left == 0) begin
        bus_rdy_    = 1'b0;
        bus_rd_data = mem_word(bus_addr);
        wait_left   = rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
      end else begin
        bus_rdy_    = 1'b1;
        bus_rd_data = $urandom;
        wait_left--;
      end
    end else begin
      bus_rdy_    = 1'b1;
      bus_rd_data = $urandom;
    end
  end

  // Drive pipeline controls; an honoured redirect is pushed to the scoreboard.
  task automatic drive(input logic s, input logic f, input logic [AW-1:0] np,
                       input logic b, input logic [AW-1:0] ba);
    redir_t r;
    stall = s; flush = f; new_pc = np; br_taken = b; br_addr = ba;
    if (f) begin
      r.at = cyc; r.tgt = np; redir_q.push_back(r);
    end else if (b && !s) begin
      r.at = cyc; r.tgt = ba; redir_q.push_back(r);
    end
  endtask

  // Monitor: reference instruction stream plus stall-hold and bus-hold rules.
  bit            chk_en = 0;
  logic [AW-1:0] exp_pc = 30'h100;
  int            n_consumed = 0;
  bit            prev_hold = 0, prev_redir = 0, prev_wait = 0;
  logic          hold_en;
  logic [AW-1:0] hold_pc, wait_addr;
  logic [DW-1:0] hold_insn;
  always @(negedge clk) begin
    if (chk_en) begin
      if (prev_hold && !if_bus_err) begin
        check("stall_hold_en", if_en_, hold_en);
        check("stall_hold_pc", if_pc, hold_pc);
        check("stall_hold_insn", if_insn, hold_insn);
      end
      if (prev_redir) check("redirect_bubble", if_en_, 1'b1);
      if (prev_wait && !if_bus_err) begin
        check("bus_req_held", bus_req_, 1'b0);
        check("bus_addr_held", bus_addr, wait_addr);
      end
      if (!if_en_ && !stall && !flush) begin
        check("stream_pc", if_pc, exp_pc);
        check("stream_insn", if_insn, mem_word(exp_pc));
        exp_pc = exp_pc + 1'b1;
        n_consumed++;
      end
      prev_redir = 0;
      while (redir_q.size() != 0 && redir_q[0].at <= cyc) begin
        exp_pc = redir_q[0].tgt;
        void'(redir_q.pop_front());
        prev_redir = 1;
      end
      prev_hold = stall && !flush;
      hold_en   = if_en_;
      hold_pc   = if_pc;
      hold_insn = if_insn;
      prev_wait = !bus_req_ && bus_rdy_;
      wait_addr = bus_addr;
    end
  end

  initial begin
    logic [AW-1:0] p;
    int nv, nreq, found_at;
    stall = 0; flush = 0; br_taken = 0; new_pc = '0; br_addr = '0;
    bus_rdy_ = 1'b1; bus_rd_data = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req_", bus_req_, 1'b1);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_if_en_", if_en_, 1'b1);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_insn", if_insn, 0);
    check("rst_if_bus_err", if_bus_err, 1'b0);
    rst = 1'b1;
    chk_en = 1;

    // Zero-wait bus: back-to-back requests from the reset vector.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zw_bus_req_", bus_req_, 1'b0);
      check("zw_bus_addr", bus_addr, 30'h100 + i);
    end

    // Two wait states: exactly one valid word every three cycles.
    fixed_waits = 2;
    repeat (10) @(negedge clk);
    nv = 0; nreq = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!if_en_) nv++;
      if (!bus_req_) nreq++;
    end
    check("ws2_valid_count", nv, 4);
    check("ws2_req_cycles", nreq, 12);

    // Stall while rdy returns, then release: pending word comes out next.
    fixed_waits = 0;
    repeat (5) @(negedge clk);
    @(posedge clk); #2; drive(1, 0, '0, 0, '0);
    @(negedge clk); p = bus_addr;
    @(posedge clk); #2; drive(0, 0, '0, 0, '0);
    @(negedge clk); check("pend_bus_req_", bus_req_, 1'b1);
    @(negedge clk);
    check("pend_out_en_", if_en_, 1'b0);
    check("pend_out_pc", if_pc, p);
    check("pend_next_addr", bus_addr, p + 1'b1);
    check("pend_next_req_", bus_req_, 1'b0);

    // Flush together with a branch during a stall in PEND: flush target wins.
    repeat (3) @(negedge clk);
    @(posedge clk); #2; drive(1, 0, '0, 0, '0);
    @(posedge clk); #2; drive(1, 1, 30'h8, 1, 30'h300);
    @(negedge clk); check("pflush_in_pend", bus_req_, 1'b1);
    @(posedge clk); #2; drive(0, 0, '0, 0, '0);
    @(negedge clk);
    check("pflush_req_", bus_req_, 1'b0);
    check("pflush_addr", bus_addr, 30'h8);
    check("pflush_en_", if_en_, 1'b1);

    // Randomized stalls, branches, flushes and bus wait states.
    @(negedge clk); rand_waits = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      drive(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFF : AW'($urandom),
            ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : AW'($urandom));
    end
    @(posedge clk); #2; drive(0, 0, '0, 0, '0);
    @(negedge clk); rand_waits = 0; fixed_waits = 0;
    repeat (20) @(negedge clk);
    check("stream_progress", (n_consumed > 300), 1'b1);

`ifdef YUTORINA_IF_BUS_TIMEOUT_EN
    // Bus stops answering: watchdog fires after TIMEOUT waiting cycles.
    bus_hang = 1;
    found_at = -1;
    for (int i = 0; i < 20 && found_at < 0; i++) begin
      @(negedge clk);
      if (if_bus_err) found_at = i;
    end
    check("wdog_fire_cycle", found_at, 4);
    check("wdog_req_off", bus_req_, 1'b1);
    @(negedge clk); check("wdog_err_pulse", if_bus_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("halt_no_req", bus_req_, 1'b1);
    end
    bus_hang = 0;
    @(posedge clk); #2; drive(0, 1, 30'h10, 0, '0);
    @(negedge clk);
    check("halt_exit_req_", bus_req_, 1'b0);
    check("halt_exit_addr", bus_addr, 30'h10);
    @(posedge clk); #2; drive(0, 0, '0, 0, '0);
    repeat (10) @(negedge clk);
`else
    found_at = 0;
    check("no_bus_err", if_bus_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/yutorina_if_stage.md
Name: yutorina_if_stage

Overview:
Instruction-fetch stage of the Yutorina pipeline and the upstream producer of the ID stage's if_en_/if_pc/if_insn inputs. It owns the PC, issues word reads to the instruction bus with a req/rdy handshake, and registers the fetched instruction for ID. It consumes ID's br_taken/br_addr redirect and the pipeline stall/flush controls.

Parameters:
ADDR_W, 30, word address width (matches WordAddrBus)
DATA_W, 32, word data width (matches WordDataBus)
RESET_VECTOR, 30'h0, PC after reset
TIMEOUT, 255, bus watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low (RESET_ENABLE = 0)
stall  in  1  pipeline stall; hold all IF outputs
flush  in  1  pipeline flush (exception/return); highest priority
new_pc  in  ADDR_W  flush target
br_taken  in  1  branch redirect from ID
br_addr  in  ADDR_W  branch target from ID
bus_req_  out  1  bus request, active-low, registered
bus_addr  out  ADDR_W  bus word address, registered
bus_rdy_  in  1  bus ready, active-low; bus_rd_data is valid in the same cycle
bus_rd_data  in  DATA_W  read data
if_en_  out  1  IF output valid, active-low
if_pc  out  ADDR_W  PC of if_insn
if_insn  out  DATA_W  fetched instruction
if_bus_err  out  1  one-cycle pulse on bus timeout (tied 0 without the optional feature)

Behaviour:
- Reset (async): pc=RESET_VECTOR, state=IDLE, bus_req_=DISABLE_, bus_addr=0, if_en_=DISABLE_, if_pc=0, if_insn=0 (NOP), if_bus_err=0, pending buffer invalid.
- Registered outputs update with #1 after posedge clk.
- Redirect rule: flush beats br_taken. br_taken is honoured only when stall=0. flush is honoured regardless of stall. The redirect target is new_pc or br_addr.
- Bus rule: after bus_req_ asserts, it and bus_addr stay constant until a cycle with bus_rdy_=0. A request is never aborted, except by the watchdog.
- FSM states: IDLE, REQ, DISCARD, PEND, HALT (HALT exists only with the optional feature).
- IDLE: on the first clock after reset, issue bus_req_=ENABLE_ with bus_addr=pc, then go to REQ. A flush in IDLE sets pc=new_pc first.
- REQ, rdy, no redirect, stall=0: if_en_=ENABLE_, if_pc=pc, if_insn=bus_rd_data, pc=pc+1. Issue the next request at pc+1 back to back and stay in REQ.
- REQ, rdy, stall=1, no flush: capture data and pc into the pending buffer, set bus_req_=DISABLE_, go to PEND. IF outputs are held.
- REQ, no rdy, stall=0, no redirect: if_en_=DISABLE_ (bubble).
- REQ, no rdy, stall=1: hold everything.
- REQ, redirect, rdy in the same cycle: pc=target, bus_addr=target, request continues, if_en_=DISABLE_, data dropped, stay in REQ.
- REQ, redirect, no rdy: pc=target, if_en_=DISABLE_, go to DISCARD.
- DISCARD: wait for rdy, then drop the data and request at pc; go to REQ. Further redirects in DISCARD only update pc.
- PEND, stall=0: present the pending instruction (if_en_=ENABLE_), pc=pending_pc+1, request pc+1, go to REQ.
- PEND, flush: drop the pending instruction, if_en_=DISABLE_, pc=new_pc, request new_pc, go to REQ.
- PC arithmetic is modulo 2^ADDR_W; all-ones wraps to 0.

Optional Feature:
YUTORINA_IF_BUS_TIMEOUT_EN
- With the macro: an 8-bit-or-wider watchdog counts consecutive cycles in REQ/DISCARD with bus_rdy_=1. The counter clears on rdy or on a state change.
- When the count reaches TIMEOUT: bus_req_=DISABLE_, if_bus_err=1 for one cycle, if_en_=DISABLE_, go to HALT.
- HALT: no requests are issued. Only a flush exits, requesting at new_pc and going to REQ.
- Without the macro: no counter, no HALT state, if_bus_err is constant 0.

Test Plan:
- Reset release, RESET_VECTOR=0x100, zero-wait bus (rdy_ always 0): bus_addr is 0x100, 0x101, 0x102 on consecutive cycles. if_pc follows one cycle later with if_en_=0 every cycle. if_insn equals memory data.
- Bus with 2 wait states per access: if_en_ shows 2 bubble cycles (1) between valid words. bus_req_ stays 0 and bus_addr stays stable throughout each access.
- stall=1 raised while rdy returns for pc=0x104: if_pc/if_insn are frozen at 0x103 and bus_req_=1. After stall drops, the next cycle presents 0x104 with if_en_=0, then the bus requests 0x105.
- br_taken=1, br_addr=0x200, asserted while the 0x106 fetch is waiting: if_en_=1 next cycle. The 0x106 response is discarded, the next request is 0x200, and the next valid output is if_pc=0x200.
- flush=1, new_pc=0x8, asserted together with br_taken=1, br_addr=0x300, during stall=1 in PEND: the pending instruction is dropped and the bus requests 0x8 (not 0x300).
- With YUTORINA_IF_BUS_TIMEOUT_EN and TIMEOUT=4, bus_rdy_ held at 1: after 4 cycles if_bus_err pulses one cycle and bus_req_=1. The block stays idle until flush, new_pc=0x10, after which it requests 0x10.
